// File: rtl/fft_reorder_buffer.sv
// Ping-pong bit-reversal reorder buffer: collects bit-reversed FFT frames, emits natural order.
// Latency: the frame's last input sample is captured on edge E, and valid_out rises after edge E+2.
// Backpressure: none. The input is an unthrottled valid stream, and a completed frame drains in exactly N cycles.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active low
//   valid_in, data_in   input sample stream, bit-reversed order within each frame
//   valid_out, data_out natural-order output stream; data_out holds its value while valid_out is low
//   first_out, last_out frame index 0 / N-1 markers (present only when REORDER_FRAME_FLAGS_EN is defined)
//
// Optional feature macro: REORDER_FRAME_FLAGS_EN (adds first_out/last_out and their registers).
module fft_reorder_buffer #(
  parameter int DW    = 12,
  parameter int LOG2N = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in,
  output logic          valid_out,
  output logic [DW-1:0] data_out
`ifdef REORDER_FRAME_FLAGS_EN
  ,
  output logic          first_out,
  output logic          last_out
`endif
);

  localparam int                N       = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Both banks live in one array; the address MSB selects the bank.
  logic [DW-1:0]    mem_q [0:2*N-1];

  logic [LOG2N-1:0] wcnt_q,  wcnt_d;
  logic             wbank_q, wbank_d;
  logic [1:0]       full_q,  full_d;
  logic [LOG2N-1:0] rcnt_q,  rcnt_d;
  logic             rbank_q, rbank_d;
  state_t           state_q, state_d;
  logic             valid_out_q, valid_out_d;
  logic [DW-1:0]    data_out_q,  data_out_d;

  logic             wr_done;
  logic             rd_en;
  logic             rd_last;
  logic             other_ready;

  assign wr_done = valid_in && (wcnt_q == CNT_MAX);
  assign rd_en   = (state_q == READ);
  assign rd_last = rd_en && (rcnt_q == CNT_MAX);

  // Writer
  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    if (valid_in) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wr_done) wbank_d = ~wbank_q;
    end
  end

  // A clear by the reader and a set by the writer on the same edge hit different banks,
  // so both take effect and the reader can continue without a bubble.
  always_comb begin
    full_d = full_q;
    if (rd_last) full_d[rbank_q] = 1'b0;
    if (wr_done) full_d[wbank_q] = 1'b1;
  end

  // Reader FSM
  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    rbank_d     = rbank_q;
    // The next bank is ready if it is already full, or if the writer completes it on this edge.
    other_ready = full_q[~rbank_q] || (wr_done && (wbank_q != rbank_q));
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = READ;
          rcnt_d  = '0;
        end
      end
      READ: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == CNT_MAX) begin
          rbank_d = ~rbank_q;
          rcnt_d  = '0;
          state_d = other_ready ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered read port; data_out keeps its last value between bursts.
  always_comb begin
    valid_out_d = rd_en;
    data_out_d  = data_out_q;
    if (rd_en) data_out_d = mem_q[{rbank_q, rcnt_q}];
  end

  // Storage has no reset; contents are retained across rst.
  always_ff @(posedge clk) begin
    if (valid_in) mem_q[{wbank_q, bitrev(wcnt_q)}] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      full_q      <= 2'b00;
      rcnt_q      <= '0;
      rbank_q     <= 1'b0;
      state_q     <= IDLE;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      full_q      <= full_d;
      rcnt_q      <= rcnt_d;
      rbank_q     <= rbank_d;
      state_q     <= state_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

`ifdef REORDER_FRAME_FLAGS_EN
  logic first_q, first_d;
  logic last_q,  last_d;

  always_comb begin
    first_d = rd_en && (rcnt_q == '0);
    last_d  = rd_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign first_out = first_q;
  assign last_out  = last_q;
`endif

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Testbench for fft_reorder_buffer: random/directed frames checked against a permutation model.
// Latency: checks that the first output appears three negedges after the last input is driven.
// Backpressure: none. The DUT has no ready signal, and the bench only inserts input gaps.
module tb_fft_reorder_buffer;

  localparam int DW    = 12;
  localparam int LOG2N = 3;
  localparam int N     = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          first_w;
  logic          last_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_drive_cyc = 0;
  int flag_idle_err = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } rec_t;

  rec_t          out_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] in_frame[$];

`ifdef REORDER_FRAME_FLAGS_EN
  fft_reorder_buffer #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out),
    .first_out(first_w), .last_out(last_w)
  );
`else
  fft_reorder_buffer #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out)
  );
  assign first_w = 1'b0;
  assign last_w  = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every valid output beat.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      rec_t r;
      r.cyc = cyc;
      r.d   = data_out;
      r.f   = first_w;
      r.l   = last_w;
      out_q.push_back(r);
    end else if (first_w !== 1'b0 || last_w !== 1'b0) begin
      flag_idle_err++;
    end
  end

  // Reference: natural-order output k is the input that arrived at position reverse(k).
  function automatic int bitrev_ref(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic void model_push(input logic [DW-1:0] d);
    in_frame.push_back(d);
    if (in_frame.size() == N) begin
      for (int k = 0; k < N; k++) exp_q.push_back(in_frame[bitrev_ref(k)]);
      in_frame.delete();
    end
  endfunction

  task automatic drive(input logic [DW-1:0] d, input bit gaps, input bit model);
    if (gaps) begin
      for (int k = 0; k < 8 && $urandom_range(1, 0) == 1; k++) begin
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = DW'($urandom_range(4095, 0));
      end
    end
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = d;
    last_drive_cyc = cyc;
    if (model) model_push(d);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget, output bit timeout);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    timeout = (out_q.size() < n);
    repeat (12) @(negedge clk);
  endtask

  task automatic start_test();
    out_q.delete();
    exp_q.delete();
    in_frame.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", data_out); end
`ifdef REORDER_FRAME_FLAGS_EN
    checks++;
    if (first_w !== 1'b0 || last_w !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got %b%b expected 00", first_w, last_w);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (out_q.size() != 0) begin errors++; $display("FAIL reset_idle: got %0d outputs expected 0", out_q.size()); end
  endtask

  task automatic test_single_frame();
    bit to;
    start_test();
    for (int i = 0; i < N; i++) drive(DW'(i), 1'b0, 1'b1);
    idle();
    wait_out(N, 60, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: got %0d outputs expected %0d", out_q.size(), N); end
    checks++;
    if (out_q.size() != N) begin errors++; $display("FAIL single_count: got %0d expected %0d", out_q.size(), N); end
    if (out_q.size() >= N) begin
      checks++;
      if (out_q[0].cyc != last_drive_cyc + 3) begin
        errors++; $display("FAIL single_latency: got cycle %0d expected %0d", out_q[0].cyc, last_drive_cyc + 3);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (out_q[i].d !== exp_q[i]) begin
          errors++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, out_q[i].d, exp_q[i]);
        end
        checks++;
        if (out_q[i].cyc != out_q[0].cyc + i) begin
          errors++; $display("FAIL single_burst[%0d]: got cycle %0d expected %0d", i, out_q[i].cyc, out_q[0].cyc + i);
        end
`ifdef REORDER_FRAME_FLAGS_EN
        checks++;
        if (out_q[i].f !== (i == 0) || out_q[i].l !== (i == N - 1)) begin
          errors++; $display("FAIL single_flags[%0d]: got %b%b expected %b%b", i, out_q[i].f, out_q[i].l, i == 0, i == N - 1);
        end
`endif
      end
    end
    checks++;
    if (valid_out !== 1'b0 || data_out !== exp_q[N-1]) begin
      errors++; $display("FAIL single_hold: got v=%b d=%0d expected v=0 d=%0d", valid_out, data_out, exp_q[N-1]);
    end
  endtask

  task automatic test_bitrev_input();
    bit to;
    int pat[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    start_test();
    for (int i = 0; i < N; i++) drive(DW'(pat[i]), 1'b0, 1'b1);
    idle();
    wait_out(N, 60, to);
    checks++;
    if (to || out_q.size() != N) begin
      errors++; $display("FAIL bitrev_count: got %0d expected %0d", out_q.size(), N);
    end
    for (int i = 0; i < N && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].d !== DW'(i)) begin
        errors++; $display("FAIL bitrev_data[%0d]: got %0d expected %0d", i, out_q[i].d, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int first_last;
    start_test();
    first_last = 0;
    for (int i = 0; i < 4 * N; i++) begin
      drive(DW'(200 + i), 1'b0, 1'b1);
      if (i == N - 1) first_last = last_drive_cyc;
    end
    idle();
    wait_out(4 * N, 120, to);
    checks++;
    if (to || out_q.size() != 4 * N) begin
      errors++; $display("FAIL b2b_count: got %0d expected %0d", out_q.size(), 4 * N);
    end
    if (out_q.size() > 0) begin
      checks++;
      if (out_q[0].cyc != first_last + 3) begin
        errors++; $display("FAIL b2b_latency: got cycle %0d expected %0d", out_q[0].cyc, first_last + 3);
      end
    end
    for (int i = 0; i < 4 * N && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].d !== exp_q[i] || out_q[i].cyc != out_q[0].cyc + i) begin
        errors++;
        $display("FAIL b2b[%0d]: got d=%0d cyc=%0d expected d=%0d cyc=%0d",
                 i, out_q[i].d, out_q[i].cyc, exp_q[i], out_q[0].cyc + i);
      end
    end
  endtask

  task automatic test_random_gaps();
    bit to;
    start_test();
    for (int i = 0; i < N; i++) drive(DW'(i), 1'b1, 1'b1);
    for (int i = 0; i < 2 * N; i++) drive(DW'($urandom_range(4095, 0)), 1'b1, 1'b1);
    idle();
    wait_out(3 * N, 400, to);
    checks++;
    if (to || out_q.size() != 3 * N) begin
      errors++; $display("FAIL gaps_count: got %0d expected %0d", out_q.size(), 3 * N);
    end
    for (int i = 0; i < 3 * N && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].d !== exp_q[i]) begin
        errors++; $display("FAIL gaps_data[%0d]: got %0d expected %0d", i, out_q[i].d, exp_q[i]);
      end
      checks++;
      if (out_q[i].cyc != out_q[i - (i % N)].cyc + (i % N)) begin
        errors++;
        $display("FAIL gaps_burst[%0d]: got cycle %0d expected %0d", i, out_q[i].cyc, out_q[i - (i % N)].cyc + (i % N));
      end
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    start_test();
    for (int i = 0; i < 5; i++) drive(DW'(50 + i), 1'b0, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || data_out !== '0) begin
        errors++; $display("FAIL midrst_outputs: got v=%b d=%0d expected v=0 d=0", valid_out, data_out);
      end
    end
    rst = 1'b1;
    out_q.delete();
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) drive(DW'(100 + i), 1'b0, 1'b1);
    idle();
    wait_out(N, 60, to);
    checks++;
    if (to || out_q.size() != N) begin
      errors++; $display("FAIL midrst_count: got %0d expected %0d", out_q.size(), N);
    end
    for (int i = 0; i < N && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].d !== exp_q[i]) begin
        errors++; $display("FAIL midrst_data[%0d]: got %0d expected %0d", i, out_q[i].d, exp_q[i]);
      end
`ifdef REORDER_FRAME_FLAGS_EN
      checks++;
      if (out_q[i].f !== (i == 0) || out_q[i].l !== (i == N - 1)) begin
        errors++; $display("FAIL midrst_flags[%0d]: got %b%b expected %b%b", i, out_q[i].f, out_q[i].l, i == 0, i == N - 1);
      end
`endif
    end
`ifdef REORDER_FRAME_FLAGS_EN
    checks++;
    if (flag_idle_err != 0) begin
      errors++; $display("FAIL flags_idle: got %0d flagged idle cycles expected 0", flag_idle_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bitrev_input();
    test_back_to_back();
    test_random_gaps();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
